// File: rtl/qs_deq_if.sv
// qs_deq_if: output beat stream of the quicksort dequeue stage.
//   out_vld_r  beat valid
//   out_sop_r  first beat of a bank
//   out_eop_r  last beat of a bank
//   out_err_r  bank error flag carried on every beat
//   out_dat_r  beat data
//   out_rdy    downstream accept
// master = dequeue stage (beat source), slave = downstream consumer.
interface qs_deq_if #(
   parameter int W = 32
);
   logic         out_vld_r;
   logic         out_sop_r;
   logic         out_eop_r;
   logic         out_err_r;
   logic [W-1:0] out_dat_r;
   logic         out_rdy;

   modport master (
      output out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r,
      input  out_rdy
   );

   modport slave (
      input  out_vld_r, out_sop_r, out_eop_r, out_err_r, out_dat_r,
      output out_rdy
   );
endinterface

// File: rtl/qs_deq.sv
// qs_pkg: shared quicksort accelerator types.
// qs_deq: dequeue stage. Waits for the current bank to be SORTED, streams its
// entries 0..n out of the bank SRAM in order, then hands the bank back as IDLE
// and moves round-robin to the next bank.
//   clk, rst        clock, asynchronous active-high reset
//   bnk_in          state of bank bnk_idx_r (muxed by the top level)
//   bnk_out_vld_r   one-cycle write-back strobe for bank bnk_idx_r
//   bnk_out_r       bank state to write back
//   bnk_idx_r       bank currently owned or awaited
//   deq_rd_en_r     SRAM read strobe, deq_rd_addr_r read address
//   deq_rd_data     SRAM read data, valid the cycle after deq_rd_en_r
//   out             beat stream (qs_deq_if.master)
// Build option: QS_DEQ_ERR_EN -- when defined, the bank err flag latched at
// unload start is carried on out_err_r; otherwise out_err_r is tied low.
package qs_pkg;
   localparam int W     = 32;
   localparam int N     = 16;
   localparam int BANKS = 2;

   typedef logic [$clog2(N)-1:0]     addr_t;
   typedef logic [$clog2(BANKS)-1:0] bank_id_t;

   typedef enum logic [2:0] {
      BANK_IDLE      = 3'd0,
      BANK_FILLING   = 3'd1,
      BANK_SORTING   = 3'd2,
      BANK_SORTED    = 3'd3,
      BANK_UNLOADING = 3'd4
   } bank_status_t;

   typedef struct packed {
      bank_status_t status;
      addr_t        n;
      logic         err;
   } bank_state_t;
endpackage

// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | awaiting SORTED on bank bnk_idx_r (first cycle after a release
//         | only advances bnk_idx_r)
// S_UNLOAD| issuing SRAM reads 0..n while read credits remain
// S_DRAIN | all reads issued; wait for FIFO and read pipe to empty
module qs_deq #(
   parameter  int W     = qs_pkg::W,
   parameter  int N     = qs_pkg::N,
   parameter  int BANKS = qs_pkg::BANKS,
   localparam int AW    = $clog2(N),
   localparam int BIW   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  qs_pkg::bank_state_t bnk_in,
   output logic               bnk_out_vld_r,
   output qs_pkg::bank_state_t bnk_out_r,
   output logic [BIW-1:0]     bnk_idx_r,
   output logic               deq_rd_en_r,
   output logic [AW-1:0]      deq_rd_addr_r,
   input  logic [W-1:0]       deq_rd_data,
   qs_deq_if.master           out
);
   typedef enum logic [1:0] {S_IDLE, S_UNLOAD, S_DRAIN} state_t;

   localparam logic [BIW-1:0] LAST_BANK = BIW'(BANKS - 1);

   state_t         state_r, state_nxt;
   logic           take, issue, rel, advance;
   logic [AW-1:0]  rd_idx_r, n_r;
   logic           en_sop_r, en_eop_r;
   logic           ret_vld_r, ret_sop_r, ret_eop_r;
   logic [W-1:0]   fifo_dat [4];
   logic           fifo_sop [4];
   logic           fifo_eop [4];
   logic [1:0]     wr_ptr_r, rd_ptr_r;
   logic [2:0]     fifo_cnt_r;
   logic [2:0]     in_use;
   logic           out_vld, push, pop, drain_done;

   // Reads are only issued against free FIFO slots, so returning data always
   // has a slot and nothing is dropped under backpressure.
   assign in_use     = fifo_cnt_r + 3'(deq_rd_en_r) + 3'(ret_vld_r);
   assign out_vld    = (fifo_cnt_r != 3'd0);
   assign push       = ret_vld_r;
   assign pop        = out_vld && out.out_rdy;
   // Counts the beat being accepted this cycle so the release lands one cycle
   // after the eop beat is taken.
   assign drain_done = ((fifo_cnt_r - 3'(pop)) == 3'd0) && !deq_rd_en_r && !ret_vld_r;

   assign out.out_vld_r = out_vld;
   assign out.out_dat_r = fifo_dat[rd_ptr_r];
   assign out.out_sop_r = out_vld && fifo_sop[rd_ptr_r];
   assign out.out_eop_r = out_vld && fifo_eop[rd_ptr_r];

`ifdef QS_DEQ_ERR_EN
   logic err_r;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       err_r <= 1'b0;
      else if (take) err_r <= bnk_in.err;
   end
   assign out.out_err_r = out_vld && err_r;
`else
   assign out.out_err_r = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= S_IDLE;
      else     state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      take      = 1'b0;
      issue     = 1'b0;
      rel       = 1'b0;
      advance   = 1'b0;
      case (state_r)
         S_IDLE: begin
            // A write-back pulse seen in IDLE is the release of the previous
            // bank; the index must not move until that write has landed.
            if (bnk_out_vld_r) begin
               advance = 1'b1;
            end else if (bnk_in.status == qs_pkg::BANK_SORTED) begin
               take      = 1'b1;
               state_nxt = S_UNLOAD;
            end
         end
         S_UNLOAD: begin
            if (in_use < 3'd4) begin
               issue = 1'b1;
               if (rd_idx_r == n_r) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_done) begin
               rel       = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bnk_out_vld_r <= 1'b0;
         bnk_out_r     <= '0;
         bnk_idx_r     <= '0;
         rd_idx_r      <= '0;
         n_r           <= '0;
         deq_rd_en_r   <= 1'b0;
         deq_rd_addr_r <= '0;
         en_sop_r      <= 1'b0;
         en_eop_r      <= 1'b0;
         ret_vld_r     <= 1'b0;
         ret_sop_r     <= 1'b0;
         ret_eop_r     <= 1'b0;
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         fifo_cnt_r    <= '0;
         for (int i = 0; i < 4; i++) begin
            fifo_dat[i] <= '0;
            fifo_sop[i] <= 1'b0;
            fifo_eop[i] <= 1'b0;
         end
      end else begin
         bnk_out_vld_r <= take || rel;
         if (take) begin
            bnk_out_r.status <= qs_pkg::BANK_UNLOADING;
            bnk_out_r.n      <= bnk_in.n;
            bnk_out_r.err    <= bnk_in.err;
            n_r              <= bnk_in.n;
            rd_idx_r         <= '0;
         end else if (rel) begin
            bnk_out_r.status <= qs_pkg::BANK_IDLE;
            bnk_out_r.n      <= '0;
            bnk_out_r.err    <= 1'b0;
         end
         if (advance) bnk_idx_r <= (bnk_idx_r == LAST_BANK) ? '0 : bnk_idx_r + 1'b1;

         deq_rd_en_r <= issue;
         if (issue) begin
            deq_rd_addr_r <= rd_idx_r;
            rd_idx_r      <= rd_idx_r + 1'b1;
            en_sop_r      <= (rd_idx_r == '0);
            en_eop_r      <= (rd_idx_r == n_r);
         end
         ret_vld_r <= deq_rd_en_r;
         ret_sop_r <= en_sop_r;
         ret_eop_r <= en_eop_r;

         if (push) begin
            fifo_dat[wr_ptr_r] <= deq_rd_data;
            fifo_sop[wr_ptr_r] <= ret_sop_r;
            fifo_eop[wr_ptr_r] <= ret_eop_r;
            wr_ptr_r           <= wr_ptr_r + 1'b1;
         end
         if (pop) rd_ptr_r <= rd_ptr_r + 1'b1;
         fifo_cnt_r <= fifo_cnt_r + 3'(push) - 3'(pop);
      end
   end
endmodule

// File: tb/tb_qs_deq.sv
module tb_qs_deq;
   localparam int BANKS = 3;
`ifdef QS_DEQ_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qs_pkg::bank_state_t bnk_in, bnk_out_r, host_st;
   qs_pkg::bank_state_t bank_q [BANKS];
   logic        bnk_out_vld_r, deq_rd_en_r, host_we;
   logic [1:0]  bnk_idx_r, host_idx;
   logic [3:0]  deq_rd_addr_r;
   logic [31:0] deq_rd_data;
   logic [31:0] sram [BANKS][16];

   int checks = 0;
   int failures = 0;

   qs_deq_if #(.W(32)) oif ();

   qs_deq #(.W(32), .N(16), .BANKS(BANKS)) dut (
      .clk           (clk),
      .rst           (rst),
      .bnk_in        (bnk_in),
      .bnk_out_vld_r (bnk_out_vld_r),
      .bnk_out_r     (bnk_out_r),
      .bnk_idx_r     (bnk_idx_r),
      .deq_rd_en_r   (deq_rd_en_r),
      .deq_rd_addr_r (deq_rd_addr_r),
      .deq_rd_data   (deq_rd_data),
      .out           (oif)
   );

   // Top-level stand-in: bank state registers, write-back and SRAM.
   assign bnk_in = (int'(bnk_idx_r) < BANKS) ? bank_q[bnk_idx_r] : '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BANKS; i++) bank_q[i] <= '0;
      end else if (bnk_out_vld_r) begin
         bank_q[bnk_idx_r] <= bnk_out_r;
      end else if (host_we) begin
         bank_q[host_idx] <= host_st;
      end
   end

   always @(posedge clk) begin
      if (deq_rd_en_r) deq_rd_data <= sram[bnk_idx_r][deq_rd_addr_r];
   end

   // Beat recorder, outstanding-read tracker and stall-stability watcher.
   logic [34:0] beat [64];
   int          beat_n = 0;
   int          pulse_n = 0;
   int          issued = 0;
   int          popped = 0;
   int          max_out = 0;
   int          stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic [35:0] prev_out = '0;

   always @(negedge clk) begin
      logic [35:0] cur;
      cur = {oif.out_vld_r, oif.out_err_r, oif.out_sop_r, oif.out_eop_r, oif.out_dat_r};
      if (prev_stall && cur !== prev_out) stall_viol++;
      prev_stall = oif.out_vld_r && !oif.out_rdy;
      prev_out   = cur;
      if (deq_rd_en_r) issued++;
      if (issued - popped > max_out) max_out = issued - popped;
      if (oif.out_vld_r && oif.out_rdy) begin
         popped++;
         if (beat_n < 64) beat[beat_n] = cur[34:0];
         beat_n++;
      end
      if (bnk_out_vld_r) pulse_n++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host(input logic [1:0] idx, input qs_pkg::bank_status_t s,
                       input logic [3:0] n, input logic e);
      host_we        = 1'b1;
      host_idx       = idx;
      host_st.status = s;
      host_st.n      = n;
      host_st.err    = e;
      step();
      host_we = 1'b0;
   endtask

   task automatic wait_idx(input logic [1:0] v, input int budget);
      int k;
      k = 0;
      while (bnk_idx_r !== v && k < budget) begin
         step();
         k++;
      end
      chk("wait_bank_idx", 64'(bnk_idx_r === v), 64'd1);
   endtask

   // beat fields: {err, sop, eop, dat}
   function automatic logic [34:0] bt(input logic e, input logic s,
                                      input logic l, input logic [31:0] d);
      return {e, s, l, d};
   endfunction

   initial begin
      int base;
      int p0;
      int k;
      rst      = 1'b1;
      host_we  = 1'b0;
      host_idx = '0;
      host_st  = '0;
      oif.out_rdy = 1'b1;
      for (int b = 0; b < BANKS; b++)
         for (int i = 0; i < 16; i++) sram[b][i] = '0;
      step();
      step();
      chk("rst_bnk_out_vld", 64'(bnk_out_vld_r), 64'd0);
      chk("rst_bnk_idx", 64'(bnk_idx_r), 64'd0);
      chk("rst_rd_en_addr", {deq_rd_en_r, deq_rd_addr_r}, 64'd0);
      chk("rst_out", {oif.out_vld_r, oif.out_sop_r, oif.out_eop_r, oif.out_err_r, oif.out_dat_r}, 64'd0);
      rst = 1'b0;
      step();

      // Bank 0, n=3, exact cycle timing with out_rdy high.
      sram[0][0] = 32'd10; sram[0][1] = 32'd20; sram[0][2] = 32'd30; sram[0][3] = 32'd40;
      host(2'd0, qs_pkg::BANK_SORTED, 4'd3, 1'b0);   // now in cycle T
      step();                                        // T+1
      chk("t1_unload_pulse", {bnk_out_vld_r, bnk_out_r}, {1'b1, qs_pkg::BANK_UNLOADING, 4'd3, 1'b0});
      step();                                        // T+2
      chk("t2_rd_issue", {deq_rd_en_r, deq_rd_addr_r}, {1'b1, 4'd0});
      step();                                        // T+3
      chk("t3_no_beat", 64'(oif.out_vld_r), 64'd0);
      for (int i = 0; i < 4; i++) begin
         step();                                     // T+4..T+7
         chk("t4_beat", {oif.out_vld_r, oif.out_sop_r, oif.out_eop_r, oif.out_dat_r},
             {1'b1, (i == 0), (i == 3), 32'(10 * (i + 1))});
      end
      step();                                        // T+8
      chk("t8_release", {bnk_out_vld_r, bnk_out_r, bnk_idx_r, oif.out_vld_r},
          {1'b1, qs_pkg::BANK_IDLE, 4'd0, 1'b0, 2'd0, 1'b0});
      step();                                        // T+9
      chk("t9_idx_advance", {bnk_out_vld_r, bnk_idx_r, bank_q[0].status},
          {1'b0, 2'd1, qs_pkg::BANK_IDLE});

      // Bank 1, n=0: single beat carrying both sop and eop.
      sram[1][0] = 32'hA5;
      base = beat_n;
      host(2'd1, qs_pkg::BANK_SORTED, 4'd0, 1'b0);
      wait_idx(2'd2, 40);
      chk("n0_beat_count", 64'(beat_n - base), 64'd1);
      chk("n0_beat", 64'(beat[base]), 64'(bt(1'b0, 1'b1, 1'b1, 32'hA5)));
      chk("n0_released", 64'(bank_q[1].status), 64'(qs_pkg::BANK_IDLE));

      // Bank 2, n=15 under out_rdy pattern 1,0,0,1; index then wraps to 0.
      for (int i = 0; i < 16; i++) sram[2][i] = 32'(i);
      base = beat_n;
      host(2'd2, qs_pkg::BANK_SORTED, 4'd15, 1'b0);
      k = 0;
      while (bnk_idx_r !== 2'd0 && k < 400) begin
         oif.out_rdy = (k % 4 == 0) || (k % 4 == 3);
         step();
         k++;
      end
      oif.out_rdy = 1'b1;
      chk("bp_wrap_to_0", 64'(bnk_idx_r), 64'd0);
      chk("bp_beat_count", 64'(beat_n - base), 64'd16);
      for (int i = 0; i < 16; i++)
         chk("bp_beat", 64'(beat[base + i]), 64'(bt(1'b0, (i == 0), (i == 15), 32'(i))));
      chk("bp_max_outstanding", 64'(max_out), 64'd4);
      chk("bp_stall_stable", 64'(stall_viol), 64'd0);

      // Bank 0 again (round-robin 0,1,2,0) with err set, n=1.
      sram[0][0] = 32'd7; sram[0][1] = 32'd8;
      base = beat_n;
      host(2'd0, qs_pkg::BANK_SORTED, 4'd1, 1'b1);
      wait_idx(2'd1, 40);
      chk("err_beat_count", 64'(beat_n - base), 64'd2);
      chk("err_beat0", 64'(beat[base]), 64'(bt(ERR_EXP, 1'b1, 1'b0, 32'd7)));
      chk("err_beat1", 64'(beat[base + 1]), 64'(bt(ERR_EXP, 1'b0, 1'b1, 32'd8)));
      chk("err_cleared", {bank_q[0].status, bank_q[0].n, bank_q[0].err},
          {qs_pkg::BANK_IDLE, 4'd0, 1'b0});

      // Bank 1, n=15, reset asserted after six beats have been accepted.
      for (int i = 0; i < 16; i++) sram[1][i] = 32'h200 + 32'(i);
      base = beat_n;
      host(2'd1, qs_pkg::BANK_SORTED, 4'd15, 1'b0);
      k = 0;
      while (beat_n - base < 6 && k < 60) begin
         step();
         k++;
      end
      chk("mid_six_beats", 64'(beat_n - base), 64'd6);
      chk("mid_beat5", 64'(beat[base + 5]), 64'(bt(1'b0, 1'b0, 1'b0, 32'h205)));
      p0 = pulse_n;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out", {oif.out_vld_r, oif.out_sop_r, oif.out_eop_r, oif.out_err_r, oif.out_dat_r}, 64'd0);
      chk("async_rst_ctl", {bnk_out_vld_r, bnk_idx_r, deq_rd_en_r, deq_rd_addr_r}, 64'd0);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      chk("rst_no_writeback", 64'(pulse_n - p0), 64'd0);
      chk("rst_idle_after", {bnk_idx_r, deq_rd_en_r, oif.out_vld_r}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
